// File: rtl/cruce_ctrl.sv
// Two-way intersection sequencer: main road (P) / side road (S), pedestrian walk
// lamp across the main road, and a night blink mode while EN is low.
module cruce_ctrl #(
    parameter int unsigned PRESC = 4,
    parameter int unsigned T_VP  = 6,
    parameter int unsigned T_A   = 2,
    parameter int unsigned T_RR  = 1,
    parameter int unsigned T_VS  = 4,
    parameter int unsigned T_BL  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       S,
    input  logic       P,
    output logic       VP,
    output logic       AP,
    output logic       RP,
    output logic       VS,
    output logic       AS,
    output logic       RS,
    output logic       B,
    output logic       W,
    output logic [2:0] FASE
);

    typedef enum logic [2:0] {
        RV_P   = 3'd0,
        AM_P   = 3'd1,
        RR_1   = 3'd2,
        RV_S   = 3'd3,
        AM_S   = 3'd4,
        RR_2   = 3'd5,
        RR_INI = 3'd6,
        BLINK  = 3'd7
    } fase_e;

    localparam logic [15:0] PRESC_LAST = 16'(PRESC - 1);
    localparam logic [15:0] VP_LAST    = 16'(T_VP - 1);
    localparam logic [15:0] A_LAST     = 16'(T_A - 1);
    localparam logic [15:0] RR_LAST    = 16'(T_RR - 1);
    localparam logic [15:0] VS_LAST    = 16'(T_VS - 1);
    localparam logic [15:0] BL_LAST    = 16'(T_BL - 1);

    fase_e       state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] timer_q, timer_d;
    logic        latch_q, latch_d;
    logic        b_q, b_d;
    logic        vp_q, vp_d, ap_q, ap_d, rp_q, rp_d;
    logic        vs_q, vs_d, as_q, as_d, rs_q, rs_d;
    logic        w_q, w_d;
    logic        tick_s, expire_s, entry_s;
    logic [15:0] last_s;

    // Next-state, timer, latch and lamp decode; lamps follow the next state so they are registered Moore outputs
    always_comb begin
        tick_s  = (presc_q == PRESC_LAST);
        presc_d = tick_s ? 16'd0 : presc_q + 16'd1;

        case (state_q)
            RV_P:        last_s = VP_LAST;
            AM_P, AM_S:  last_s = A_LAST;
            RV_S:        last_s = VS_LAST;
            BLINK:       last_s = BL_LAST;
            default:     last_s = RR_LAST;
        endcase
        expire_s = tick_s && (timer_q == last_s);

        state_d = state_q;
        if (!EN) begin
            state_d = BLINK;
        end else begin
            case (state_q)
                RV_P:    state_d = (expire_s && (S || latch_q)) ? AM_P : RV_P;
                AM_P:    state_d = expire_s ? RR_1 : AM_P;
                RR_1:    state_d = expire_s ? RV_S : RR_1;
                RV_S:    state_d = expire_s ? AM_S : RV_S;
                AM_S:    state_d = expire_s ? RR_2 : AM_S;
                RR_2:    state_d = expire_s ? RV_P : RR_2;
                RR_INI:  state_d = expire_s ? RV_P : RR_INI;
                BLINK:   state_d = RR_INI;
                default: state_d = RR_INI;
            endcase
        end
        entry_s = (state_d != state_q);

        // RV_P holds its timer at the last value so a late request leaves on the next tick
        if (entry_s) begin
            timer_d = 16'd0;
        end else if (!tick_s) begin
            timer_d = timer_q;
        end else if ((state_q == RV_P) && (timer_q == VP_LAST)) begin
            timer_d = timer_q;
        end else if ((state_q == BLINK) && (timer_q == BL_LAST)) begin
            timer_d = 16'd0;
        end else begin
            timer_d = timer_q + 16'd1;
        end

        if ((state_d != BLINK) || entry_s) begin
            b_d = 1'b0;
        end else if (expire_s) begin
            b_d = ~b_q;
        end else begin
            b_d = b_q;
        end

        if ((state_q == RV_S) || (state_q == BLINK)) begin
            latch_d = 1'b0;
        end else if (P) begin
            latch_d = 1'b1;
        end else begin
            latch_d = latch_q;
        end

        vp_d = 1'b0; ap_d = 1'b0; rp_d = 1'b1;
        vs_d = 1'b0; as_d = 1'b0; rs_d = 1'b1;
        w_d  = 1'b0;
        case (state_d)
            RV_P:    begin vp_d = 1'b1; rp_d = 1'b0; end
            AM_P:    begin ap_d = 1'b1; rp_d = 1'b0; end
            RV_S:    begin vs_d = 1'b1; rs_d = 1'b0; w_d = 1'b1; end
            AM_S:    begin as_d = 1'b1; rs_d = 1'b0; end
            BLINK:   begin rp_d = 1'b0; rs_d = 1'b0; ap_d = b_d; as_d = b_d; end
            default: begin rp_d = 1'b1; rs_d = 1'b1; end
        endcase
    end

    // State, counters and lamp registers with asynchronous reset to the all-red start-up phase
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RR_INI;
            presc_q <= 16'd0;
            timer_q <= 16'd0;
            latch_q <= 1'b0;
            b_q     <= 1'b0;
            vp_q    <= 1'b0;
            ap_q    <= 1'b0;
            rp_q    <= 1'b1;
            vs_q    <= 1'b0;
            as_q    <= 1'b0;
            rs_q    <= 1'b1;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            latch_q <= latch_d;
            b_q     <= b_d;
            vp_q    <= vp_d;
            ap_q    <= ap_d;
            rp_q    <= rp_d;
            vs_q    <= vs_d;
            as_q    <= as_d;
            rs_q    <= rs_d;
            w_q     <= w_d;
        end
    end

    assign VP   = vp_q;
    assign AP   = ap_q;
    assign RP   = rp_q;
    assign VS   = vs_q;
    assign AS   = as_q;
    assign RS   = rs_q;
    assign B    = b_q;
    assign W    = w_q;
    assign FASE = state_q;

endmodule

// File: tb/tb_cruce_ctrl.sv
// Scoreboard bench for cruce_ctrl: stimulus queues expected phase changes (code and
// length of the phase just left), a monitor pops and checks them on every FASE change.
module tb_cruce_ctrl;

    logic       CLK, RST, EN, S, P;
    logic       VP, AP, RP, VS, AS, RS, B, W;
    logic [2:0] FASE;

    typedef struct {
        logic [2:0] fase;
        int         len;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    cruce_ctrl dut (
        .CLK(CLK), .RST(RST), .EN(EN), .S(S), .P(P),
        .VP(VP), .AP(AP), .RP(RP), .VS(VS), .AS(AS), .RS(RS),
        .B(B), .W(W), .FASE(FASE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Bench copy of the prescaler phase: rising edges since reset release
    always @(posedge CLK or negedge RST) begin
        if (!RST) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic logic [7:0] outv();
        return {VP, AP, RP, VS, AS, RS, W, B};
    endfunction

    // {VP,AP,RP,VS,AS,RS,W,B} on phase entry
    function automatic logic [7:0] exp_out(input logic [2:0] f);
        case (f)
            3'd0:    return 8'b1000_0100;
            3'd1:    return 8'b0100_0100;
            3'd3:    return 8'b0011_0010;
            3'd4:    return 8'b0010_1000;
            3'd7:    return 8'b0000_0000;
            default: return 8'b0010_0100;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, want, $time);
        end
    endtask

    task automatic push(input logic [2:0] f, input int l);
        exp_t e;
        e.fase = f;
        e.len  = l;
        q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_p();
        P = 1'b1;
        @(negedge CLK);
        P = 1'b0;
    endtask

    task automatic wait_fase(input logic [2:0] f);
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            if (FASE == f) break;
        end
        chk("wait_fase", FASE, f);
    endtask

    task automatic push_cycle_tail();
        push(3'd2, 8); push(3'd3, 4); push(3'd4, 16); push(3'd5, 8); push(3'd0, 4);
    endtask

    // Monitor: phase code, length of the left phase and entry lamps on each change
    initial begin
        logic [2:0] prev;
        int         len;
        exp_t       e;
        prev = 3'd6;
        len  = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                prev = FASE;
                len  = 0;
            end else if (FASE != prev) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change actual=%0d expected=%0d t=%0t", FASE, prev, $time);
                end else begin
                    e = q.pop_front();
                    chk("phase_code", FASE, e.fase);
                    if (e.len != 0) chk("phase_len", len, e.len);
                    chk("entry_lamps", outv(), exp_out(FASE));
                end
                prev = FASE;
                len  = 1;
            end else begin
                len++;
                if (FASE != 3'd7) chk("steady_lamps", outv(), exp_out(FASE));
            end
        end
    end

    initial begin
        int t[$];
        logic pb;
        RST = 1'b0; EN = 1'b1; S = 1'b0; P = 1'b0;
        cycles(3);
        @(posedge CLK); #2;
        chk("reset_lamps", outv(), 8'b0010_0100);
        chk("reset_fase", FASE, 6);
        push(3'd0, 4);
        RST = 1'b1;

        // idle: main green forever
        wait_fase(3'd0);
        cycles(200);
        chk("idle_fase", FASE, 0);
        chk("idle_vp", VP, 1);

        // side car held, then dropped after leaving RV_P
        S = 1'b1;
        push(3'd1, 0); push_cycle_tail();
        push(3'd1, 24); push_cycle_tail();
        wait_fase(3'd1); wait_fase(3'd0); wait_fase(3'd1);
        S = 1'b0;
        wait_fase(3'd0);

        // pedestrian press at cycle 5 of RV_P, plus an ignored press in RV_S
        push(3'd1, 24); push_cycle_tail();
        cycles(4);
        pulse_p();
        wait_fase(3'd3);
        cycles(3);
        pulse_p();
        wait_fase(3'd0);
        cycles(60);
        chk("ped_latch_cleared", FASE, 0);

        // press during AM_S gives exactly one extra side phase
        push(3'd1, 0); push_cycle_tail();
        push(3'd1, 24); push_cycle_tail();
        pulse_p();
        wait_fase(3'd4);
        cycles(2);
        pulse_p();
        wait_fase(3'd0); wait_fase(3'd1); wait_fase(3'd0);
        cycles(60);
        chk("ams_press_once", FASE, 0);

        // night mode from RV_S
        push(3'd1, 0); push(3'd2, 8); push(3'd3, 4); push(3'd7, 0);
        pulse_p();
        wait_fase(3'd3);
        cycles(3);
        EN = 1'b0;
        @(negedge CLK);
        chk("night_fase", FASE, 7);
        chk("night_lamps_off", {VP, RP, VS, RS, W}, 0);
        pb = B;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            chk("blink_ap", AP, B);
            chk("blink_as", AS, B);
            if (B != pb) t.push_back(i);
            pb = B;
        end
        chk("blink_toggles", t.size(), 5);
        if (t.size() >= 3) begin
            chk("blink_period_a", t[1] - t[0], 4);
            chk("blink_period_b", t[2] - t[1], 4);
        end
        pulse_p();
        push(3'd6, 0);
        push(3'd0, 4 - ((cyc + 1) % 4));
        EN = 1'b1;
        wait_fase(3'd0);
        cycles(40);
        chk("night_exit_idle", FASE, 0);

        // asynchronous reset in AM_S with a pending pedestrian latch
        push(3'd1, 0); push(3'd2, 8); push(3'd3, 4); push(3'd4, 16);
        pulse_p();
        wait_fase(3'd4);
        cycles(2);
        pulse_p();
        cycles(1);
        #2 RST = 1'b0;
        #1;
        chk("async_reset_lamps", outv(), 8'b0010_0100);
        chk("async_reset_fase", FASE, 6);
        cycles(3);
        push(3'd0, 4);
        @(posedge CLK); #2;
        RST = 1'b1;
        wait_fase(3'd0);
        cycles(60);
        chk("restart_idle", FASE, 0);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
